tl_scratch_responder: RTL and testbench



---
 rtl/tl_scratch_pkg.sv | 37 +++
 rtl/tl_scratch_responder_if.sv | 46 ++++
 rtl/tl_scratch_mem.sv | 37 +++
 rtl/tl_scratch_responder.sv | 204 ++++++++++++++++++++
 tb/tb_tl_scratch_responder.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_scratch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_scratch_pkg
// Description : Shared TileLink-UL opcodes, responder FSM states and the
//               beat-count helper for the scratchpad responder.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_scratch_pkg;

    // A-channel request opcodes
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    // D-channel response opcodes
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Wide enough for the largest encodable size (2^15 bytes = 4096 beats)
    localparam int BEAT_W = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        ACK    = 2'd2,
        READ   = 2'd3
    } state_e;

    // Number of 64-bit beats carried by a transfer of 2^size bytes
    function automatic logic [BEAT_W-1:0] beats_from_size(input logic [3:0] size);
        if (size <= 4'd3) begin
            return 13'd1;
        end
        return 13'd1 << (size - 4'd3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_scratch_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : tl_scratch_responder_if
// Description : TileLink-UL A/D channel bundle between an initiator (master)
//               and the scratchpad responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface tl_scratch_responder_if;
    logic        auto_in_a_ready;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [3:0]  auto_in_a_bits_size;
    logic [31:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_d_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [3:0]  auto_in_d_bits_size;
    logic [2:0]  auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    modport master (
        input  auto_in_a_ready,
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
               auto_in_a_bits_address, auto_in_a_bits_mask, auto_in_a_bits_data,
        output auto_in_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
               auto_in_d_bits_size, auto_in_d_bits_sink, auto_in_d_bits_denied,
               auto_in_d_bits_data, auto_in_d_bits_corrupt
    );

    modport slave (
        output auto_in_a_ready,
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
               auto_in_a_bits_address, auto_in_a_bits_mask, auto_in_a_bits_data,
        input  auto_in_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
               auto_in_d_bits_size, auto_in_d_bits_sink, auto_in_d_bits_denied,
               auto_in_d_bits_data, auto_in_d_bits_corrupt
    );
endinterface
`default_nettype wire

// File: rtl/tl_scratch_mem.sv
`default_nettype none
// ============================================================================
// Module      : tl_scratch_mem
// Description : DEPTH_WORDS x 64-bit flop array with a byte-enable write port
//               and a combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_scratch_mem #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  wire logic          clk_i,
    input  wire logic          we_i,
    input  wire logic [AW-1:0] waddr_i,
    input  wire logic [7:0]    wmask_i,
    input  wire logic [63:0]   wdata_i,
    input  wire logic [AW-1:0] raddr_i,
    output logic      [63:0]   rdata_o
);

    logic [63:0] mem_q [DEPTH_WORDS];

    // Byte-lane write: only lanes with their mask bit set are updated
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < 8; l++) begin
                if (wmask_i[l]) begin
                    mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/tl_scratch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tl_scratch_responder
// Description : TileLink-UL responder terminating Get / PutFullData /
//               PutPartialData (single and burst) on a local scratchpad.
//               One transaction outstanding; no A/D overlap.
//               Optional macro TL_SCRATCH_ASSERT_EN compiles protocol checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_scratch_responder
    import tl_scratch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
    parameter int          DEPTH_WORDS = 512,
    parameter int          MAX_SIZE    = 6
) (
    input wire logic              clock,
    input wire logic              reset,
    tl_scratch_responder_if.slave tl
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 3;

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   last_q, last_d;
    logic [3:0]          size_q, size_d;
    logic                denied_q, denied_d;

    logic                a_fire, d_fire;
    logic                a_supported, a_is_put, a_denied;
    logic [32:0]         a_off;
    logic [AW-1:0]       a_idx;
    logic [BEAT_W-1:0]   a_beats;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [63:0]         mem_rdata;

    assign tl.auto_in_a_ready = !reset && (state_q == IDLE || state_q == WBURST);
    assign tl.auto_in_d_valid = !reset && (state_q == ACK  || state_q == READ);
    assign a_fire = tl.auto_in_a_valid && tl.auto_in_a_ready;
    assign d_fire = tl.auto_in_d_valid && tl.auto_in_d_ready;

    // 33-bit offset: addresses below BASE_ADDR wrap to a huge value and fail the range test
    assign a_off       = {1'b0, tl.auto_in_a_bits_address} - {1'b0, BASE_ADDR};
    assign a_idx       = a_off[AW+2:3];
    assign a_is_put    = (tl.auto_in_a_bits_opcode == PUT_FULL) ||
                         (tl.auto_in_a_bits_opcode == PUT_PARTIAL);
    assign a_supported = a_is_put || (tl.auto_in_a_bits_opcode == GET);
    assign a_denied    = (a_off >= RANGE_BYTES) ||
                         (tl.auto_in_a_bits_size > 4'(MAX_SIZE)) || !a_supported;

    // Unsupported opcodes are single-beat, except 2/3 which still carry a data burst
    always_comb begin
        if (a_supported ||
            ((tl.auto_in_a_bits_opcode == 3'd2 || tl.auto_in_a_bits_opcode == 3'd3) &&
             tl.auto_in_a_bits_size > 4'd3)) begin
            a_beats = beats_from_size(tl.auto_in_a_bits_size);
        end else begin
            a_beats = 13'd1;
        end
    end

    // Next-state, counter and write-port control
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        last_d    = last_q;
        size_d    = size_q;
        denied_d  = denied_q;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    size_d   = tl.auto_in_a_bits_size;
                    denied_d = a_denied;
                    last_d   = a_beats - 13'd1;
                    if (tl.auto_in_a_bits_opcode == GET) begin
                        state_d = READ;
                        beat_d  = '0;
                        idx_d   = a_idx;
                    end else begin
                        mem_we    = a_is_put && !a_denied;
                        mem_waddr = a_idx;
                        if (a_beats == 13'd1) begin
                            state_d = ACK;
                            beat_d  = '0;
                            idx_d   = a_idx;
                        end else begin
                            state_d = WBURST;
                            beat_d  = 13'd1;
                            idx_d   = a_idx + 1'b1;
                        end
                    end
                end
            end
            WBURST: begin
                if (a_fire) begin
                    mem_we = !denied_q;
                    if (beat_q == last_q) begin
                        state_d = ACK;
                    end else begin
                        beat_d = beat_q + 13'd1;
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (d_fire) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (d_fire) begin
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 13'd1;
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction context registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            beat_q   <= '0;
            last_q   <= '0;
            size_q   <= '0;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
            size_q   <= size_d;
            denied_q <= denied_d;
        end
    end

    tl_scratch_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wmask_i (tl.auto_in_a_bits_mask),
        .wdata_i (tl.auto_in_a_bits_data),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    // D bits derive only from registers (plus the array read), so they hold during stalls
    assign tl.auto_in_d_bits_opcode  = (state_q == READ) ? ACCESS_ACK_DATA : ACCESS_ACK;
    assign tl.auto_in_d_bits_param   = 2'd0;
    assign tl.auto_in_d_bits_size    = size_q;
    assign tl.auto_in_d_bits_sink    = 3'd0;
    assign tl.auto_in_d_bits_denied  = denied_q;
    assign tl.auto_in_d_bits_data    = (state_q == READ && !denied_q) ? mem_rdata : 64'd0;
    assign tl.auto_in_d_bits_corrupt = (state_q == READ) && denied_q;

`ifdef TL_SCRATCH_ASSERT_EN
    logic [7:0] get_mask_exp;

    // Lanes a Get of this size/address is expected to request
    always_comb begin
        case (tl.auto_in_a_bits_size)
            4'd0:    get_mask_exp = 8'h01 << tl.auto_in_a_bits_address[2:0];
            4'd1:    get_mask_exp = 8'h03 << tl.auto_in_a_bits_address[2:0];
            4'd2:    get_mask_exp = 8'h0F << tl.auto_in_a_bits_address[2:0];
            default: get_mask_exp = 8'hFF;
        endcase
    end

    a_aligned: assert property (@(posedge clock) disable iff (reset)
        (tl.auto_in_a_valid && state_q == IDLE) |->
        ((tl.auto_in_a_bits_address & ((32'd1 << tl.auto_in_a_bits_size) - 32'd1)) == 32'd0));
    a_size_ok: assert property (@(posedge clock) disable iff (reset)
        (tl.auto_in_a_valid && state_q == IDLE) |-> (tl.auto_in_a_bits_size <= 4'(MAX_SIZE)));
    a_get_mask: assert property (@(posedge clock) disable iff (reset)
        (tl.auto_in_a_valid && state_q == IDLE && tl.auto_in_a_bits_opcode == GET) |->
        (tl.auto_in_a_bits_mask == get_mask_exp));
    a_stable: assert property (@(posedge clock) disable iff (reset)
        (tl.auto_in_a_valid && !tl.auto_in_a_ready) |=>
        $stable({tl.auto_in_a_bits_opcode, tl.auto_in_a_bits_size, tl.auto_in_a_bits_address,
                 tl.auto_in_a_bits_mask, tl.auto_in_a_bits_data}));
    d_stable: assert property (@(posedge clock) disable iff (reset)
        (tl.auto_in_d_valid && !tl.auto_in_d_ready) |=>
        $stable({tl.auto_in_d_bits_opcode, tl.auto_in_d_bits_size, tl.auto_in_d_bits_denied,
                 tl.auto_in_d_bits_data, tl.auto_in_d_bits_corrupt}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_scratch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_scratch_responder
// Description : Self-checking bench for tl_scratch_responder: fixed vector
//               table, multi-cycle corner sequences and randomized traffic
//               against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_scratch_responder;
    import tl_scratch_pkg::*;

    localparam logic [31:0] BASE  = 32'h0800_0000;
    localparam int          DEPTH = 512;
    localparam int          MAXS  = 6;
    localparam logic [31:0] END_A = BASE + 32'(8 * DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl_scratch_responder_if bus ();

    tl_scratch_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .MAX_SIZE    (MAXS)
    ) dut (
        .clock (clk),
        .reset (rst),
        .tl    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model [DEPTH];
    logic [63:0] g_data [8];
    logic [7:0]  g_mask [8];
    bit          tog = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        exp_den;
        logic [2:0]  exp_opc;
        logic [63:0] exp_data;
        bit          chk_data;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pattern(input int w);
        return 64'hC0DE_0000_0000_0000 | 64'(w);
    endfunction

    function automatic bit ref_denied(input logic [2:0] op, input logic [3:0] size,
                                      input logic [31:0] addr);
        longint off;
        off = longint'(addr) - longint'(BASE);
        return (off < 0) || (off >= 8 * DEPTH) || (int'(size) > MAXS) ||
               !(op == 3'd0 || op == 3'd1 || op == 3'd4);
    endfunction

    function automatic int ref_beats(input logic [2:0] op, input logic [3:0] size);
        if (op == 3'd0 || op == 3'd1 || op == 3'd4 || ((op == 3'd2 || op == 3'd3) && size > 4'd3))
            return (size <= 4'd3) ? 1 : (1 << (int'(size) - 3));
        return 1;
    endfunction

    function automatic int ref_index(input logic [31:0] addr, input int beat);
        longint off;
        off = longint'(addr) - longint'(BASE);
        return int'(((off >>> 3) + longint'(beat)) & longint'(DEPTH - 1));
    endfunction

    task automatic model_write(input int idx, input logic [7:0] mask, input logic [63:0] data);
        for (int l = 0; l < 8; l++)
            if (mask[l]) model[idx][8*l +: 8] = data[8*l +: 8];
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                             input logic [7:0] mask, input logic [63:0] data);
        int n;
        n = 0;
        @(negedge clk);
        bus.auto_in_a_valid        = 1'b1;
        bus.auto_in_a_bits_opcode  = op;
        bus.auto_in_a_bits_size    = size;
        bus.auto_in_a_bits_address = addr;
        bus.auto_in_a_bits_mask    = mask;
        bus.auto_in_a_bits_data    = data;
        while (!bus.auto_in_a_ready) begin
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL a_accept_timeout: a_ready low for 50 cycles, required 1");
                bus.auto_in_a_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.auto_in_a_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: alternate ready, 2: random ready
    task automatic recv_beat(input int mode, output logic [2:0] opc, output logic den,
                             output logic cor, output logic [63:0] dat, output logic [3:0] sz);
        int          n;
        bit          have;
        logic [13:0] snap_c, cur_c;
        logic [63:0] snap_d;
        n = 0; have = 0; snap_c = '0; snap_d = '0;
        opc = '0; den = 1'b0; cor = 1'b0; dat = '0; sz = '0;
        while (n < 100) begin
            if (bus.auto_in_d_valid) begin
                cur_c = {bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_param, bus.auto_in_d_bits_size,
                         bus.auto_in_d_bits_sink, bus.auto_in_d_bits_denied, bus.auto_in_d_bits_corrupt};
                if (have) begin
                    check("d_ctrl_stable", 64'(cur_c), 64'(snap_c));
                    check("d_data_stable", bus.auto_in_d_bits_data, snap_d);
                end
                snap_c = cur_c;
                snap_d = bus.auto_in_d_bits_data;
                have   = 1;
                case (mode)
                    0:       bus.auto_in_d_ready = 1'b1;
                    1:       begin tog = ~tog; bus.auto_in_d_ready = tog; end
                    default: bus.auto_in_d_ready = 1'($urandom_range(0, 1));
                endcase
                if (bus.auto_in_d_ready) begin
                    opc = bus.auto_in_d_bits_opcode;
                    den = bus.auto_in_d_bits_denied;
                    cor = bus.auto_in_d_bits_corrupt;
                    dat = bus.auto_in_d_bits_data;
                    sz  = bus.auto_in_d_bits_size;
                    check("d_param_sink", 64'({bus.auto_in_d_bits_param, bus.auto_in_d_bits_sink}), 64'd0);
                    @(posedge clk);
                    #1;
                    bus.auto_in_d_ready = 1'b0;
                    return;
                end
            end else if (have) begin
                check("d_valid_held", 64'(bus.auto_in_d_valid), 64'd1);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        errors++;
        $display("FAIL d_response_timeout: no D beat in 100 cycles, required one");
    endtask

    // Full transaction checked against the reference model
    task automatic run_txn(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                           input int mode, input bit given);
        bit          den;
        int          nb;
        logic [2:0]  opc;
        logic        rden, rcor;
        logic [63:0] rdat;
        logic [3:0]  rsz;
        den = ref_denied(op, size, addr);
        nb  = ref_beats(op, size);
        if (!given) begin
            for (int b = 0; b < 8; b++) begin
                g_data[b] = {$urandom, $urandom};
                g_mask[b] = (op == PUT_PARTIAL) ? 8'($urandom) : 8'hFF;
            end
        end
        if (op == GET) begin
            send_beat(op, size, addr, 8'hFF, 64'd0);
            check("get_latency", 64'(bus.auto_in_d_valid), 64'd1);
            for (int b = 0; b < nb; b++) begin
                recv_beat(mode, opc, rden, rcor, rdat, rsz);
                check("get_opcode", 64'(opc), 64'(ACCESS_ACK_DATA));
                check("get_denied", 64'(rden), 64'(den));
                check("get_corrupt", 64'(rcor), 64'(den));
                check("get_size", 64'(rsz), 64'(size));
                check($sformatf("get_data_beat%0d", b), rdat, den ? 64'd0 : model[ref_index(addr, b)]);
            end
        end else begin
            for (int b = 0; b < nb; b++) begin
                send_beat(op, size, addr, g_mask[b % 8], g_data[b % 8]);
                if (!den) model_write(ref_index(addr, b), g_mask[b % 8], g_data[b % 8]);
            end
            check("put_latency", 64'(bus.auto_in_d_valid), 64'd1);
            recv_beat(mode, opc, rden, rcor, rdat, rsz);
            check("put_opcode", 64'(opc), 64'(ACCESS_ACK));
            check("put_denied", 64'(rden), 64'(den));
            check("put_corrupt", 64'(rcor), 64'd0);
            check("put_size", 64'(rsz), 64'(size));
        end
        @(negedge clk);
        check("idle_after_txn", 64'({bus.auto_in_d_valid, bus.auto_in_a_ready}), 64'b01);
    endtask

    initial begin
        logic [2:0]  opc;
        logic        rden, rcor;
        logic [63:0] rdat;
        logic [3:0]  rsz;

        bus.auto_in_a_valid        = 1'b0;
        bus.auto_in_a_bits_opcode  = '0;
        bus.auto_in_a_bits_size    = '0;
        bus.auto_in_a_bits_address = '0;
        bus.auto_in_a_bits_mask    = '0;
        bus.auto_in_a_bits_data    = '0;
        bus.auto_in_d_ready        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a_ready", 64'(bus.auto_in_a_ready), 64'd0);
        check("reset_d_valid", 64'(bus.auto_in_d_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready_valid", 64'({bus.auto_in_d_valid, bus.auto_in_a_ready}), 64'b01);
        check("post_reset_d_ctrl", 64'({bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_param,
              bus.auto_in_d_bits_size, bus.auto_in_d_bits_sink, bus.auto_in_d_bits_denied,
              bus.auto_in_d_bits_corrupt}), 64'd0);
        check("post_reset_d_data", bus.auto_in_d_bits_data, 64'd0);

        // Preload every word with a known pattern using 8-beat bursts
        for (int w = 0; w < DEPTH / 8; w++) begin
            for (int b = 0; b < 8; b++) begin
                g_data[b] = pattern(w * 8 + b);
                g_mask[b] = 8'hFF;
            end
            run_txn(PUT_FULL, 4'd6, BASE + 32'(64 * w), 0, 1);
        end

        // Fixed single-beat vectors
        vec[0]  = '{PUT_FULL,    4'd3, BASE + 32'h10, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0, ACCESS_ACK,      64'd0, 0};
        vec[1]  = '{GET,         4'd3, BASE + 32'h10, 8'hFF, 64'd0, 1'b0, ACCESS_ACK_DATA, 64'hDEAD_BEEF_0123_4567, 1};
        vec[2]  = '{PUT_PARTIAL, 4'd3, BASE + 32'h10, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ACCESS_ACK,      64'd0, 0};
        vec[3]  = '{GET,         4'd3, BASE + 32'h10, 8'hFF, 64'd0, 1'b0, ACCESS_ACK_DATA, 64'hDEAD_BEEF_FFFF_FFFF, 1};
        vec[4]  = '{GET,         4'd3, END_A,         8'hFF, 64'd0, 1'b1, ACCESS_ACK_DATA, 64'd0, 1};
        vec[5]  = '{PUT_FULL,    4'd3, END_A,         8'hFF, 64'h1234, 1'b1, ACCESS_ACK,   64'd0, 0};
        vec[6]  = '{GET,         4'd3, BASE,          8'hFF, 64'd0, 1'b0, ACCESS_ACK_DATA, 64'hC0DE_0000_0000_0000, 1};
        vec[7]  = '{3'd5,        4'd2, BASE + 32'h20, 8'h0F, 64'd0, 1'b1, ACCESS_ACK,      64'd0, 0};
        vec[8]  = '{3'd2,        4'd3, BASE + 32'h20, 8'hFF, 64'd7, 1'b1, ACCESS_ACK,      64'd0, 0};
        vec[9]  = '{GET,         4'd2, BASE + 32'h24, 8'hF0, 64'd0, 1'b0, ACCESS_ACK_DATA, 64'hC0DE_0000_0000_0004, 1};
        vec[10] = '{GET,         4'd3, BASE - 32'd8,  8'hFF, 64'd0, 1'b1, ACCESS_ACK_DATA, 64'd0, 1};
        vec[11] = '{GET,         4'd3, END_A - 32'd8, 8'hFF, 64'd0, 1'b0, ACCESS_ACK_DATA, 64'hC0DE_0000_0000_01FF, 1};

        for (int i = 0; i < NV; i++) begin
            send_beat(vec[i].op, vec[i].size, vec[i].addr, vec[i].mask, vec[i].data);
            check($sformatf("vec%0d_latency", i), 64'(bus.auto_in_d_valid), 64'd1);
            recv_beat(0, opc, rden, rcor, rdat, rsz);
            check($sformatf("vec%0d_opcode", i), 64'(opc), 64'(vec[i].exp_opc));
            check($sformatf("vec%0d_denied", i), 64'(rden), 64'(vec[i].exp_den));
            check($sformatf("vec%0d_corrupt", i), 64'(rcor),
                  64'((vec[i].exp_opc == ACCESS_ACK_DATA) ? vec[i].exp_den : 1'b0));
            check($sformatf("vec%0d_size", i), 64'(rsz), 64'(vec[i].size));
            if (vec[i].chk_data) check($sformatf("vec%0d_data", i), rdat, vec[i].exp_data);
            if (!vec[i].exp_den && (vec[i].op == PUT_FULL || vec[i].op == PUT_PARTIAL))
                model_write(ref_index(vec[i].addr, 0), vec[i].mask, vec[i].data);
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), 64'({bus.auto_in_d_valid, bus.auto_in_a_ready}), 64'b01);
        end

        // 8-beat write of 0..7, then 8-beat read with alternating d_ready
        for (int b = 0; b < 8; b++) begin
            g_data[b] = 64'(b);
            g_mask[b] = 8'hFF;
        end
        run_txn(PUT_FULL, 4'd6, BASE + 32'h40, 0, 1);
        for (int b = 0; b < 8; b++) check($sformatf("burst_model_beat%0d", b), model[8 + b], 64'(b));
        run_txn(GET, 4'd6, BASE + 32'h40, 1, 0);

        // Opcode 2 with a burst size is consumed for all 4 beats; size > MAX is denied
        run_txn(3'd2, 4'd5, BASE + 32'h100, 0, 0);
        run_txn(PUT_FULL, 4'd7, BASE, 2, 0);
        run_txn(GET, 4'd6, BASE + 32'h100, 2, 0);

        // Reset during beat 3 of an 8-beat write
        for (int b = 0; b < 3; b++) begin
            send_beat(PUT_FULL, 4'd6, BASE + 32'h80, 8'hFF, 64'h100 + 64'(b));
            model_write(ref_index(BASE + 32'h80, b), 8'hFF, 64'h100 + 64'(b));
        end
        @(negedge clk);
        bus.auto_in_a_valid       = 1'b1;
        bus.auto_in_a_bits_data   = 64'h103;
        rst                       = 1'b1;
        #1;
        check("mid_reset_a_ready", 64'(bus.auto_in_a_ready), 64'd0);
        @(negedge clk);
        bus.auto_in_a_valid = 1'b0;
        rst                 = 1'b0;
        #1;
        check("after_reset_idle", 64'({bus.auto_in_d_valid, bus.auto_in_a_ready}), 64'b01);
        run_txn(GET, 4'd6, BASE + 32'h80, 2, 0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            int          r, w;
            logic [2:0]  op;
            logic [3:0]  size;
            logic [31:0] addr, amask;
            r    = int'($urandom_range(0, 9));
            op   = (r <= 2) ? PUT_FULL : (r <= 4) ? PUT_PARTIAL : (r <= 8) ? GET : 3'd5;
            size = 4'($urandom_range(0, 6));
            amask = ~((32'd1 << size) - 32'd1);
            w    = int'($urandom_range(0, DEPTH - 1));
            addr = (32'(w * 8) + 32'($urandom_range(0, 7))) & amask;
            if ($urandom_range(0, 15) == 0) addr = END_A + addr;
            else addr = BASE + addr;
            run_txn(op, size, addr, 2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
